// File: rtl/i2d_pkg.sv
// i2d_pkg
//   Shared definitions for the i2d instruction decode stage: 6-bit opcode
//   encodings, instruction field bit positions and the packed control-bit
//   bundle carried from decode into the ID/EX pipeline register.
//   Fetch and execute import the same constants so that all stages agree
//   on the instruction format.
package i2d_pkg;

    // Opcode encodings in bits [31:26] of the instruction word.
    localparam logic [5:0] I2D_INS_NOP  = 6'h00;
    localparam logic [5:0] I2D_INS_ADD  = 6'h01;
    localparam logic [5:0] I2D_INS_SUB  = 6'h02;
    localparam logic [5:0] I2D_INS_AND  = 6'h03;
    localparam logic [5:0] I2D_INS_OR   = 6'h04;
    localparam logic [5:0] I2D_INS_ADDI = 6'h08;
    localparam logic [5:0] I2D_INS_ORI  = 6'h09;
    localparam logic [5:0] I2D_INS_LW   = 6'h10;
    localparam logic [5:0] I2D_INS_SW   = 6'h11;
    localparam logic [5:0] I2D_INS_BEQ  = 6'h18;
    localparam logic [5:0] I2D_INS_J    = 6'h19;

    // Least-significant bit of each field inside the instruction word.
    localparam int I2D_OP_LSB = 26;
    localparam int I2D_RD_LSB = 21;
    localparam int I2D_RS_LSB = 16;
    localparam int I2D_RT_LSB = 11;

    // Control bits handed to execute alongside each decoded instruction.
    typedef struct packed {
        logic rfWe;
        logic memRd;
        logic memWr;
        logic branch;
        logic jump;
    } ctrl_t;

endpackage

// File: rtl/i2d_decode.sv
// i2d_decode
//   Purely combinational instruction decoder. Splits a 32-bit word into its
//   register fields, builds the extended immediate, derives the control bits
//   and flags which register fields the instruction actually reads.
// Ports:
//   ins_i      fetched instruction word
//   op_o       opcode [31:26]
//   rd_o/rs_o/rt_o  register fields [25:21], [20:16], [15:11]
//   imm_o      sign/zero extended immediate (0 when unused)
//   ctrl_o     control bits (write-back, memory, branch, jump)
//   illegal_o  opcode not defined
//   useRs_o/useRt_o/useRd_o  field is a source operand
import i2d_pkg::*;

module i2d_decode #(
    parameter int RF_AW = 5
) (
    input  logic [31:0]      ins_i,
    output logic [5:0]       op_o,
    output logic [RF_AW-1:0] rd_o,
    output logic [RF_AW-1:0] rs_o,
    output logic [RF_AW-1:0] rt_o,
    output logic [31:0]      imm_o,
    output ctrl_t            ctrl_o,
    output logic             illegal_o,
    output logic             useRs_o,
    output logic             useRt_o,
    output logic             useRd_o
);

    logic writesRd;

    assign op_o = ins_i[31:I2D_OP_LSB];
    assign rd_o = ins_i[I2D_RD_LSB +: RF_AW];
    assign rs_o = ins_i[I2D_RS_LSB +: RF_AW];
    assign rt_o = ins_i[I2D_RT_LSB +: RF_AW];

    // Opcode table. Write-back is qualified by rd != 0 after the case so
    // that writes to the hardwired zero register never reach execute.
    always_comb begin
        imm_o     = '0;
        ctrl_o    = '0;
        illegal_o = 1'b0;
        useRs_o   = 1'b0;
        useRt_o   = 1'b0;
        useRd_o   = 1'b0;
        writesRd  = 1'b0;
        case (op_o)
            I2D_INS_NOP: ;
            I2D_INS_ADD, I2D_INS_SUB, I2D_INS_AND, I2D_INS_OR: begin
                writesRd = 1'b1;
                useRs_o  = 1'b1;
                useRt_o  = 1'b1;
            end
            I2D_INS_ADDI: begin
                imm_o    = {{16{ins_i[15]}}, ins_i[15:0]};
                writesRd = 1'b1;
                useRs_o  = 1'b1;
            end
            I2D_INS_ORI: begin
                imm_o    = {16'h0000, ins_i[15:0]};
                writesRd = 1'b1;
                useRs_o  = 1'b1;
            end
            I2D_INS_LW: begin
                imm_o        = {{16{ins_i[15]}}, ins_i[15:0]};
                writesRd     = 1'b1;
                ctrl_o.memRd = 1'b1;
                useRs_o      = 1'b1;
            end
            I2D_INS_SW: begin
                imm_o        = {{16{ins_i[15]}}, ins_i[15:0]};
                ctrl_o.memWr = 1'b1;
                useRs_o      = 1'b1;
                useRd_o      = 1'b1;
            end
            I2D_INS_BEQ: begin
                imm_o         = {{16{ins_i[15]}}, ins_i[15:0]};
                ctrl_o.branch = 1'b1;
                useRs_o       = 1'b1;
                useRd_o       = 1'b1;
            end
            I2D_INS_J: begin
                // Word offset: shift imm26 left by two, then sign-extend.
                imm_o       = {{4{ins_i[25]}}, ins_i[25:0], 2'b00};
                ctrl_o.jump = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase
        ctrl_o.rfWe = writesRd & (rd_o != '0);
    end

endmodule

// File: rtl/i2d_id.sv
// i2d_id
//   Instruction decode stage. Decodes the fetched word, owns the ID/EX
//   pipeline register, detects the load-use hazard and drives fetch
//   back-pressure.
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   if_ins, if_pc       fetched word and its PC
//   if_busy, if_err     fetch word invalid this cycle / fetch bus error
//   ex_stall, flush     execute back-pressure / kill ID contents
//   if_dis              hold fetch PC and re-present the same word
//   rf_ra, rf_rb        combinational register-file read addresses
//   id_*                ID/EX pipeline register outputs
import i2d_pkg::*;

module i2d_id #(
    parameter int RF_AW = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      if_ins,
    input  logic [31:0]      if_pc,
    input  logic             if_busy,
    input  logic             if_err,
    input  logic             ex_stall,
    input  logic             flush,
    output logic             if_dis,
    output logic [RF_AW-1:0] rf_ra,
    output logic [RF_AW-1:0] rf_rb,
    output logic             id_valid,
    output logic [31:0]      id_pc,
    output logic [5:0]       id_op,
    output logic [RF_AW-1:0] id_rd,
    output logic [RF_AW-1:0] id_rs,
    output logic [RF_AW-1:0] id_rt,
    output logic [31:0]      id_imm,
    output logic             id_rf_we,
    output logic             id_mem_rd,
    output logic             id_mem_wr,
    output logic             id_branch,
    output logic             id_jump,
    output logic             id_illegal,
    output logic             id_fetch_err
);

    logic [5:0]       decOp;
    logic [RF_AW-1:0] decRd, decRs, decRt;
    logic [31:0]      decImm;
    ctrl_t            decCtrl;
    logic             decIllegal, useRs, useRt, useRd;

    logic             valid_q, valid_d;
    logic [31:0]      pc_q, pc_d;
    logic [5:0]       op_q, op_d;
    logic [RF_AW-1:0] rd_q, rd_d, rs_q, rs_d, rt_q, rt_d;
    logic [31:0]      imm_q, imm_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             illegal_q, illegal_d;
    logic             fetchErr_q, fetchErr_d;
    logic             hazard;

    i2d_decode #(.RF_AW(RF_AW)) u_decode (
        .ins_i     (if_ins),
        .op_o      (decOp),
        .rd_o      (decRd),
        .rs_o      (decRs),
        .rt_o      (decRt),
        .imm_o     (decImm),
        .ctrl_o    (decCtrl),
        .illegal_o (decIllegal),
        .useRs_o   (useRs),
        .useRt_o   (useRt),
        .useRd_o   (useRd)
    );

    // Stores and branches carry their second source in the rd field.
    assign rf_ra = decRs;
    assign rf_rb = useRd ? decRd : decRt;

    // A load in ID whose destination feeds the incoming word needs one
    // bubble. Once the bubble clears id_valid the hazard drops by itself.
    assign hazard = valid_q & ctrl_q.memRd & (rd_q != '0) & ~if_busy &
                    ((useRs & (decRs == rd_q)) |
                     (useRt & (decRt == rd_q)) |
                     (useRd & (decRd == rd_q)));

    // A flush redirects fetch, so it must never be frozen at the same time.
    assign if_dis = ~flush & (ex_stall | hazard);

    // Next-state of the ID/EX register: flush, stall, bubble, capture.
    // Bubbles clear the valid and every flag EX acts on; the data fields
    // are left as they were since nothing downstream looks at them.
    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        op_d       = op_q;
        rd_d       = rd_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        imm_d      = imm_q;
        ctrl_d     = ctrl_q;
        illegal_d  = illegal_q;
        fetchErr_d = fetchErr_q;
        if (flush || (!ex_stall && (hazard || if_busy))) begin
            valid_d    = 1'b0;
            ctrl_d     = '0;
            illegal_d  = 1'b0;
            fetchErr_d = 1'b0;
        end else if (!ex_stall) begin
            valid_d    = 1'b1;
            pc_d       = if_pc;
            op_d       = decOp;
            rd_d       = decRd;
            rs_d       = decRs;
            rt_d       = decRt;
            imm_d      = decImm;
            // A faulted fetch must reach EX as a pure exception carrier.
            ctrl_d     = if_err ? '0 : decCtrl;
            illegal_d  = decIllegal & ~if_err;
            fetchErr_d = if_err;
        end
    end

    // ID/EX pipeline register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            op_q       <= I2D_INS_NOP;
            rd_q       <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            imm_q      <= '0;
            ctrl_q     <= '0;
            illegal_q  <= 1'b0;
            fetchErr_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            imm_q      <= imm_d;
            ctrl_q     <= ctrl_d;
            illegal_q  <= illegal_d;
            fetchErr_q <= fetchErr_d;
        end
    end

    assign id_valid     = valid_q;
    assign id_pc        = pc_q;
    assign id_op        = op_q;
    assign id_rd        = rd_q;
    assign id_rs        = rs_q;
    assign id_rt        = rt_q;
    assign id_imm       = imm_q;
    assign id_rf_we     = ctrl_q.rfWe;
    assign id_mem_rd    = ctrl_q.memRd;
    assign id_mem_wr    = ctrl_q.memWr;
    assign id_branch    = ctrl_q.branch;
    assign id_jump      = ctrl_q.jump;
    assign id_illegal   = illegal_q;
    assign id_fetch_err = fetchErr_q;

endmodule

// File: tb/tb_i2d_id.sv
// tb_i2d_id
//   Self-checking bench for i2d_id. Each cycle the expected ID/EX contents
//   are computed from a reference model of the decode stage and queued;
//   after the clock edge the entry is popped and compared with the DUT.
module tb_i2d_id;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] imm;
        logic        we;
        logic        mrd;
        logic        mwr;
        logic        br;
        logic        jmp;
        logic        ill;
        logic        ferr;
    } idState_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_ins, if_pc;
    logic        if_busy, if_err, ex_stall, flush;
    logic        if_dis;
    logic [4:0]  rf_ra, rf_rb;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [5:0]  id_op;
    logic [4:0]  id_rd, id_rs, id_rt;
    logic [31:0] id_imm;
    logic        id_rf_we, id_mem_rd, id_mem_wr, id_branch, id_jump;
    logic        id_illegal, id_fetch_err;

    int          checks = 0;
    int          errors = 0;
    idState_t    model;
    idState_t    expQ[$];
    logic        lastIfDis;

    i2d_id #(.RF_AW(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_ins       (if_ins),
        .if_pc        (if_pc),
        .if_busy      (if_busy),
        .if_err       (if_err),
        .ex_stall     (ex_stall),
        .flush        (flush),
        .if_dis       (if_dis),
        .rf_ra        (rf_ra),
        .rf_rb        (rf_rb),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .id_op        (id_op),
        .id_rd        (id_rd),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_imm       (id_imm),
        .id_rf_we     (id_rf_we),
        .id_mem_rd    (id_mem_rd),
        .id_mem_wr    (id_mem_wr),
        .id_branch    (id_branch),
        .id_jump      (id_jump),
        .id_illegal   (id_illegal),
        .id_fetch_err (id_fetch_err)
    );

    always #5 clk = ~clk;

    // Hard time limit so a wedged run still ends with a report.
    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] time limit expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [4:0] rt);
        return {op, rd, rs, rt, 11'd0};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [15:0] imm);
        return {op, rd, rs, imm};
    endfunction

    // Which register fields each opcode reads as a source.
    function automatic logic readsReg(input logic [31:0] ins, input logic [4:0] r);
        logic [5:0] op;
        op = ins[31:26];
        if (op >= 6'h01 && op <= 6'h04) return (ins[20:16] == r) || (ins[15:11] == r);
        if (op == 6'h08 || op == 6'h09 || op == 6'h10) return ins[20:16] == r;
        if (op == 6'h11 || op == 6'h18) return (ins[20:16] == r) || (ins[25:21] == r);
        return 1'b0;
    endfunction

    function automatic idState_t modelDecode(input logic [31:0] ins, input logic [31:0] pc,
                                             input logic err);
        idState_t s;
        logic     wr;
        s = '0;
        wr = 1'b0;
        s.valid = 1'b1;
        s.pc = pc;
        s.op = ins[31:26];
        s.rd = ins[25:21];
        s.rs = ins[20:16];
        s.rt = ins[15:11];
        case (s.op)
            6'h00: ;
            6'h01, 6'h02, 6'h03, 6'h04: wr = 1'b1;
            6'h08: begin s.imm = {{16{ins[15]}}, ins[15:0]}; wr = 1'b1; end
            6'h09: begin s.imm = {16'd0, ins[15:0]}; wr = 1'b1; end
            6'h10: begin s.imm = {{16{ins[15]}}, ins[15:0]}; wr = 1'b1; s.mrd = 1'b1; end
            6'h11: begin s.imm = {{16{ins[15]}}, ins[15:0]}; s.mwr = 1'b1; end
            6'h18: begin s.imm = {{16{ins[15]}}, ins[15:0]}; s.br = 1'b1; end
            6'h19: begin s.imm = {{4{ins[25]}}, ins[25:0], 2'b00}; s.jmp = 1'b1; end
            default: s.ill = 1'b1;
        endcase
        s.we = wr && (s.rd != 5'd0);
        if (err) begin
            {s.we, s.mrd, s.mwr, s.br, s.jmp, s.ill} = '0;
            s.ferr = 1'b1;
        end
        return s;
    endfunction

    function automatic idState_t bubble(input idState_t s);
        idState_t b;
        b = s;
        {b.valid, b.we, b.mrd, b.mwr, b.br, b.jmp, b.ill, b.ferr} = '0;
        return b;
    endfunction

    function automatic idState_t dutState();
        idState_t s;
        s = {id_valid, id_pc, id_op, id_rd, id_rs, id_rt, id_imm, id_rf_we, id_mem_rd,
             id_mem_wr, id_branch, id_jump, id_illegal, id_fetch_err};
        return s;
    endfunction

    // One cycle: drive inputs, predict, check combinational outputs, then
    // compare the registered result after the rising edge.
    task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic busy, input logic err, input logic stall,
                                 input logic fl, input logic rs);
        idState_t nxt;
        logic     hz, dis;
        logic     rdSrc;
        @(negedge clk);
        if_ins = ins; if_pc = pc; if_busy = busy; if_err = err;
        ex_stall = stall; flush = fl; rst = rs;
        hz = model.valid && model.mrd && (model.rd != 5'd0) && !busy && readsReg(ins, model.rd);
        dis = !fl && (stall || hz);
        if (rs) nxt = '0;
        else if (fl) nxt = bubble(model);
        else if (stall) nxt = model;
        else if (hz || busy) nxt = bubble(model);
        else nxt = modelDecode(ins, pc, err);
        expQ.push_back(nxt);
        rdSrc = (ins[31:26] == 6'h11) || (ins[31:26] == 6'h18);
        #1;
        lastIfDis = if_dis;
        checkOutput("if_dis", if_dis, dis);
        checkOutput("rf_ra", rf_ra, ins[20:16]);
        checkOutput("rf_rb", rf_rb, rdSrc ? ins[25:21] : ins[15:11]);
        @(posedge clk);
        #1;
        model = expQ.pop_front();
        checkOutput("idreg", dutState(), model);
    endtask

    task automatic step(input logic [31:0] ins, input logic [31:0] pc);
        applyStimulus(ins, pc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [5:0] opList [12] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h08,
                                6'h09, 6'h10, 6'h11, 6'h18, 6'h19, 6'h3F};

    initial begin
        rst = 1'b1; if_ins = '0; if_pc = '0; if_busy = 1'b0; if_err = 1'b0;
        ex_stall = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        model = '0;

        // Reset in the middle of a stream
        step(rtype(6'h01, 5'd1, 5'd2, 5'd3), 32'h0);
        checkOutput("add_valid", id_valid, 1'b1);
        applyStimulus(rtype(6'h01, 5'd1, 5'd2, 5'd3), 32'h4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("rst_ifdis", lastIfDis, 1'b0);
        checkOutput("rst_valid", id_valid, 1'b0);
        checkOutput("rst_op", id_op, 6'h00);
        checkOutput("rst_imm", id_imm, 32'h0);

        // Immediates
        step(itype(6'h08, 5'd3, 5'd1, 16'hFFFC), 32'h100);
        checkOutput("addi_pc", id_pc, 32'h100);
        checkOutput("addi_imm", id_imm, 32'hFFFFFFFC);
        checkOutput("addi_we", id_rf_we, 1'b1);
        step(itype(6'h09, 5'd3, 5'd1, 16'hFFFC), 32'h104);
        checkOutput("ori_imm", id_imm, 32'h0000FFFC);
        step({6'h19, 26'h3FFFFFF}, 32'h108);
        checkOutput("j_imm", id_imm, 32'hFFFFFFFC);
        checkOutput("j_jump", id_jump, 1'b1);

        // Load-use interlock, then a load to r0
        step(itype(6'h10, 5'd5, 5'd1, 16'h0004), 32'h200);
        step(rtype(6'h01, 5'd6, 5'd5, 5'd2), 32'h204);
        checkOutput("lu_ifdis", lastIfDis, 1'b1);
        checkOutput("lu_bubble", id_valid, 1'b0);
        step(rtype(6'h01, 5'd6, 5'd5, 5'd2), 32'h204);
        checkOutput("lu_capture", id_valid, 1'b1);
        checkOutput("lu_pc", id_pc, 32'h204);
        step(itype(6'h10, 5'd0, 5'd1, 16'h0004), 32'h208);
        step(rtype(6'h01, 5'd6, 5'd0, 5'd0), 32'h20C);
        checkOutput("lu0_ifdis", lastIfDis, 1'b0);
        checkOutput("lu0_valid", id_valid, 1'b1);

        // Stall hold for three cycles, then release
        step(itype(6'h11, 5'd7, 5'd1, 16'h0010), 32'h300);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(rtype(6'h02, 5'd4, 5'd7, 5'd1), 32'h304, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            checkOutput("stall_ifdis", lastIfDis, 1'b1);
            checkOutput("stall_pc", id_pc, 32'h300);
        end
        step(rtype(6'h02, 5'd4, 5'd7, 5'd1), 32'h304);
        checkOutput("stall_release", id_pc, 32'h304);

        // Stall together with a hazard: hold first, bubble after release
        step(itype(6'h10, 5'd9, 5'd1, 16'h0000), 32'h380);
        applyStimulus(rtype(6'h01, 5'd2, 5'd9, 5'd1), 32'h384, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(rtype(6'h01, 5'd2, 5'd9, 5'd1), 32'h384);
        step(rtype(6'h01, 5'd2, 5'd9, 5'd1), 32'h384);

        // Flush beats stall and the pending load-use
        step(itype(6'h10, 5'd8, 5'd1, 16'h0000), 32'h400);
        applyStimulus(rtype(6'h01, 5'd2, 5'd8, 5'd1), 32'h404, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("flush_ifdis", lastIfDis, 1'b0);
        checkOutput("flush_valid", id_valid, 1'b0);
        step(rtype(6'h01, 5'd2, 5'd8, 5'd1), 32'h500);
        checkOutput("flush_nobubble", id_valid, 1'b1);

        // Fetch anomalies
        applyStimulus(rtype(6'h01, 5'd2, 5'd3, 5'd4), 32'h600, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("busy_bubble", id_valid, 1'b0);
        applyStimulus(32'h04000000, 32'h604, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("err_ferr", id_fetch_err, 1'b1);
        checkOutput("err_we", id_rf_we, 1'b0);
        checkOutput("err_ill", id_illegal, 1'b0);
        applyStimulus({6'h3F, 26'h0AB_CDEF}, 32'h608, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step({6'h3F, 5'd4, 21'h0}, 32'h60C);
        checkOutput("ill_flag", id_illegal, 1'b1);
        checkOutput("ill_ctrl", {id_rf_we, id_mem_rd, id_mem_wr, id_branch, id_jump}, 5'b0);

        // Random mix on a small register set to provoke hazards
        for (int i = 0; i < 60; i++) begin
            logic [31:0] ins;
            ins = $urandom;
            ins[31:26] = opList[$urandom_range(0, 11)];
            ins[25:21] = 5'($urandom_range(0, 3));
            ins[20:16] = 5'($urandom_range(0, 3));
            ins[15:11] = 5'($urandom_range(0, 3));
            applyStimulus(ins, 32'h1000 + 32'(i * 4),
                          ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 29) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
